// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register, one-entry skid buffer for stalls, and redirect/flush.
// Optional macro IF_MISALIGN_TRAP_EN adds misalign_err, flagging redirects to non-word-aligned targets.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [5:0]  id_OPcode,
    output logic [5:0]  id_Fun
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic {FETCH, HOLD} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } ifid_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_inc;
    ifid_t       id_q, id_d, skid_q, skid_d;
    logic        vld_q, vld_d;
    logic        accept;

    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        id_d      = id_q;
        vld_d     = vld_q;
        skid_d    = skid_q;
        imem_req  = (state_q == FETCH);
        imem_addr = pc_q;
        accept    = imem_req && imem_ready;

        if (redirect) begin
            // Target is forced word-aligned; any word landing this cycle is dropped.
            pc_d      = redirect_pc & ~32'h3;
            vld_d     = 1'b0;
            id_d.inst = '0;
            skid_d    = '0;
            state_d   = FETCH;
        end else if (flush) begin
            vld_d     = 1'b0;
            id_d.inst = '0;
            skid_d    = '0;
            state_d   = FETCH;
            if (accept) pc_d = pc_inc;
        end else if (state_q == HOLD) begin
            if (!stall) begin
                id_d    = skid_q;
                vld_d   = 1'b1;
                state_d = FETCH;
            end
        end else if (accept) begin
            pc_d = pc_inc;
            if (stall) begin
                // Memory already answered; park the word instead of re-fetching it.
                skid_d  = '{inst: imem_rdata, pc4: pc_inc};
                state_d = HOLD;
            end else begin
                id_d  = '{inst: imem_rdata, pc4: pc_inc};
                vld_d = 1'b1;
            end
        end else if (!stall) begin
            vld_d     = 1'b0;
            id_d.inst = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            id_q    <= '0;
            vld_q   <= 1'b0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            id_q    <= id_d;
            vld_q   <= vld_d;
            skid_q  <= skid_d;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) misalign_err <= 1'b0;
        else        misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
    end
`endif

    assign id_inst   = id_q.inst;
    assign id_pc4    = id_q.pc4;
    assign id_valid  = vld_q;
    assign id_OPcode = id_q.inst[31:26];
    assign id_Fun    = id_q.inst[5:0];

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: a queue-based fetch model predicts every edge, a monitor compares.
module tb_if_stage;
    localparam logic [31:0] PC_RST = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n, imem_req, imem_ready, stall, flush, redirect, id_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_inst, id_pc4;
    logic [5:0]  id_OPcode, id_Fun;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    if_stage #(.PC_RESET(PC_RST)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_inst(id_inst), .id_pc4(id_pc4),
        .id_valid(id_valid), .id_OPcode(id_OPcode), .id_Fun(id_Fun)
`ifdef IF_MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0040_0000: mem_word = 32'h0000_0020;
            32'h0040_0004: mem_word = 32'h2008_0005;
            default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h1234_5677;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } word_t;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        pc4_ok;
        logic        req;
        logic [31:0] addr;
        logic        mis;
    } exp_t;

    exp_t  exp_q[$];
    word_t pend[$];
    int    checks = 0, errors = 0;

    // Reference model: instructions accepted from memory queue up and drain one per unstalled edge.
    logic [31:0] m_pc = PC_RST, m_inst = '0, m_pc4 = '0;
    logic        m_valid = 1'b0, m_pc4_ok = 1'b0, m_mis;

    always @(posedge clk) begin
        exp_t  e;
        word_t w;
        m_mis = 1'b0;
        if (!rst_n) begin
            m_pc = PC_RST; pend.delete();
            m_valid = 0; m_inst = 0; m_pc4 = 0; m_pc4_ok = 1;
        end else if (redirect) begin
            m_pc = {redirect_pc[31:2], 2'b00}; pend.delete();
            m_mis = (redirect_pc[1:0] != 0);
            m_valid = 0; m_inst = 0; m_pc4_ok = 0;
        end else if (flush) begin
            if (pend.size() == 0 && imem_ready) m_pc = m_pc + 4;
            pend.delete();
            m_valid = 0; m_inst = 0; m_pc4_ok = 0;
        end else begin
            if (pend.size() == 0 && imem_ready) begin
                pend.push_back('{inst: mem_word(m_pc), pc4: m_pc + 32'd4});
                m_pc = m_pc + 4;
            end
            if (!stall) begin
                if (pend.size() != 0) begin
                    w = pend.pop_front();
                    m_valid = 1; m_inst = w.inst; m_pc4 = w.pc4; m_pc4_ok = 1;
                end else begin
                    m_valid = 0; m_inst = 0; m_pc4_ok = 0;
                end
            end
        end
        e = '{valid: m_valid, inst: m_inst, pc4: m_pc4, pc4_ok: m_pc4_ok,
              req: (pend.size() == 0), addr: m_pc, mis: m_mis};
        exp_q.push_back(e);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("id_valid", {31'b0, id_valid}, {31'b0, e.valid});
            chk("id_inst", id_inst, e.inst);
            chk("id_OPcode", {26'b0, id_OPcode}, {26'b0, e.inst[31:26]});
            chk("id_Fun", {26'b0, id_Fun}, {26'b0, e.inst[5:0]});
            if (e.pc4_ok) chk("id_pc4", id_pc4, e.pc4);
            chk("imem_req", {31'b0, imem_req}, {31'b0, e.req});
            if (e.req) chk("imem_addr", imem_addr, e.addr);
`ifdef IF_MISALIGN_TRAP_EN
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
`endif
        end
    end

    task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                        input logic fl, input logic st, input logic rdy, input int n);
        rst_n = r; redirect = rd; redirect_pc = rpc; flush = fl; stall = st; imem_ready = rdy;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1, 2);                 // reset
        step(1, 0, 0, 0, 0, 1, 4);                 // streaming add, addi, ...
        step(1, 0, 0, 0, 1, 1, 3);                 // stall with memory ready -> park
        step(1, 0, 0, 0, 0, 1, 2);                 // release
        step(1, 1, 32'h0000_1000, 1, 0, 1, 1);     // redirect beats flush
        step(1, 0, 0, 0, 0, 1, 2);
        step(1, 0, 0, 0, 0, 0, 2);                 // wait states -> bubbles
        step(0, 0, 0, 0, 0, 0, 1);                 // reset mid-wait
        step(1, 0, 0, 0, 0, 1, 2);
        step(1, 1, 32'h0000_1002, 0, 0, 1, 1);     // misaligned target
        step(1, 0, 0, 0, 0, 1, 2);
        step(1, 1, 32'hFFFF_FFF8, 0, 0, 1, 1);     // pc wrap
        step(1, 0, 0, 0, 0, 1, 4);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
            step($urandom_range(99) != 0, $urandom_range(19) == 0, rpc,
                 $urandom_range(19) == 0, $urandom_range(3) == 0, $urandom_range(9) < 7, 1);
        end
        step(1, 0, 0, 0, 0, 1, 2);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
